// File: rtl/irq_sched_pkg.sv
// -----------------------------------------------------------------------------
// irq_sched_pkg
// Shared definitions for the interrupt scheduler timing engine and its
// register slice.
//   - default timer / counter widths
//   - CTRL register bit positions (START, ENABLE)
//   - FSM state encoding, which is also visible through the status register
// -----------------------------------------------------------------------------
package irq_sched_pkg;

   localparam int IRQ_SCHED_CNT_W = 32;
   localparam int IRQ_SCHED_NUM_W = 16;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_ENABLE_BIT = 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DELAY    = 3'd1,
      RUN      = 3'd2,
      WAIT_ACK = 3'd3
   } irq_sched_state_e;

endpackage

// File: rtl/irq_sched_timer.sv
// -----------------------------------------------------------------------------
// irq_sched_timer
// Loadable down-counter with a registered expiry flag.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   load      load load_val this cycle (wins over en)
//   en        decrement this cycle (stops at zero)
//   load_val  value to load
//   expired   registered: high while the counter holds zero
// -----------------------------------------------------------------------------
module irq_sched_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count;
      if (load) begin
         count_d = load_val;
      end else if (en && (count != '0)) begin
         count_d = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         expired <= 1'b0;
      end else begin
         count   <= count_d;
         // Flag tracks the value being written so it lines up with the count.
         expired <= (count_d == '0);
      end
   end

endmodule

// File: rtl/irq_sched_core.sv
// -----------------------------------------------------------------------------
// irq_sched_core
// Timing engine of the interrupt scheduler. After an accepted start it waits
// cfg_delay+1 cycles, raises irq, and then re-fires every max(cfg_period,1)
// cycles, holding irq high until software acknowledges it.
//
// Optional feature macro: IRQ_SCHED_OVERRUN_CNT_EN
//   defined   : overrun_cnt counts period ticks that expire while waiting
//               for an acknowledge
//   undefined : overrun_cnt is tied to zero and those ticks are dropped
//
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   cfg_enable        level; low forces IDLE
//   cfg_start         one-cycle start pulse
//   cfg_delay         cycles from start to first interrupt
//   cfg_period        cycles between interrupts (0 behaves as 1)
//   cfg_count         number of interrupts, 0 = unlimited
//   irq_ack           one-cycle acknowledge
//   irq               interrupt level (registered)
//   busy              high outside IDLE
//   state_o           current state encoding
//   fired_cnt         interrupts raised since last accepted start (saturating)
//   overrun_cnt       ticks lost while awaiting ack (saturating)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no activity, irq low, waiting for an enabled start
// DELAY    | counting the initial delay towards the first interrupt
// RUN      | counting towards the next periodic interrupt, irq low
// WAIT_ACK | irq high, timer still running, waiting for irq_ack
// -----------------------------------------------------------------------------
module irq_sched_core
   import irq_sched_pkg::*;
#(
   parameter int CNT_W = IRQ_SCHED_CNT_W,
   parameter int NUM_W = IRQ_SCHED_NUM_W
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             cfg_enable,
   input  logic             cfg_start,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [NUM_W-1:0] cfg_count,
   input  logic             irq_ack,
   output logic             irq,
   output logic             busy,
   output logic [2:0]       state_o,
   output logic [NUM_W-1:0] fired_cnt,
   output logic [NUM_W-1:0] overrun_cnt
);

   irq_sched_state_e state_q;
   irq_sched_state_e state_d;

   // The timer is loaded with period-1 so that fire edges are spaced by
   // exactly the effective period.
   logic [CNT_W-1:0] period_m1_sh;
   logic [NUM_W-1:0] count_sh;
   logic [CNT_W-1:0] cfg_period_m1;

   logic             irq_d;
   logic             fire;
   logic             latch;
   logic             final_irq;
   logic             tmr_load;
   logic             tmr_en;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_expired;

`ifdef IRQ_SCHED_OVERRUN_CNT_EN
   logic             overrun;
`endif

   assign cfg_period_m1 = (cfg_period == '0) ? '0 : cfg_period - CNT_W'(1);
   assign final_irq     = (count_sh != '0) && (fired_cnt == count_sh);

   assign busy    = (state_q != IDLE);
   assign state_o = state_q;

   irq_sched_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (ACLK),
      .rst      (ARESET),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      irq_d    = 1'b0;
      fire     = 1'b0;
      latch    = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = period_m1_sh;
`ifdef IRQ_SCHED_OVERRUN_CNT_EN
      overrun  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               latch    = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = cfg_delay;
               state_d  = DELAY;
            end
         end
         DELAY, RUN: begin
            tmr_en = 1'b1;
            if (tmr_expired) begin
               fire     = 1'b1;
               tmr_load = 1'b1;
               irq_d    = 1'b1;
               state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            tmr_en = 1'b1;
            irq_d  = 1'b1;
            if (irq_ack && final_irq) begin
               state_d = IDLE;
               irq_d   = 1'b0;
            end else if (irq_ack && tmr_expired) begin
               // Ack and expiry together: immediate re-fire, irq stays high.
               fire     = 1'b1;
               tmr_load = 1'b1;
            end else if (irq_ack) begin
               state_d = RUN;
               irq_d   = 1'b0;
            end else if (tmr_expired) begin
               tmr_load = 1'b1;
`ifdef IRQ_SCHED_OVERRUN_CNT_EN
               overrun  = 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Disable overrides everything; counters and timer hold.
      if (!cfg_enable) begin
         state_d  = IDLE;
         irq_d    = 1'b0;
         fire     = 1'b0;
         latch    = 1'b0;
         tmr_load = 1'b0;
         tmr_en   = 1'b0;
`ifdef IRQ_SCHED_OVERRUN_CNT_EN
         overrun  = 1'b0;
`endif
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         irq          <= 1'b0;
         fired_cnt    <= '0;
         period_m1_sh <= '0;
         count_sh     <= '0;
      end else begin
         irq <= irq_d;
         if (latch) begin
            period_m1_sh <= cfg_period_m1;
            count_sh     <= cfg_count;
         end
         if (latch) begin
            fired_cnt <= '0;
         end else if (fire && (fired_cnt != '1)) begin
            fired_cnt <= fired_cnt + NUM_W'(1);
         end
      end
   end

`ifdef IRQ_SCHED_OVERRUN_CNT_EN
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         overrun_cnt <= '0;
      end else if (latch) begin
         overrun_cnt <= '0;
      end else if (overrun && (overrun_cnt != '1)) begin
         overrun_cnt <= overrun_cnt + NUM_W'(1);
      end
   end
`else
   assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_irq_sched_core.sv
// -----------------------------------------------------------------------------
// tb_irq_sched_core
// Directed scenarios followed by randomized traffic, checked every cycle
// against a time-based reference model (absolute fire times, not a timer).
// -----------------------------------------------------------------------------
module tb_irq_sched_core;
   import irq_sched_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cfg_enable;
   logic        cfg_start;
   logic [31:0] cfg_delay;
   logic [31:0] cfg_period;
   logic [15:0] cfg_count;
   logic        irq_ack;
   logic        irq;
   logic        busy;
   logic [2:0]  state_o;
   logic [15:0] fired_cnt;
   logic [15:0] overrun_cnt;

   irq_sched_core dut (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .cfg_enable  (cfg_enable),
      .cfg_start   (cfg_start),
      .cfg_delay   (cfg_delay),
      .cfg_period  (cfg_period),
      .cfg_count   (cfg_count),
      .irq_ack     (irq_ack),
      .irq         (irq),
      .busy        (busy),
      .state_o     (state_o),
      .fired_cnt   (fired_cnt),
      .overrun_cnt (overrun_cnt)
   );

   always #5 ACLK = ~ACLK;

`ifdef IRQ_SCHED_OVERRUN_CNT_EN
   localparam int OVR_EXP = 3;
`else
   localparam int OVR_EXP = 0;
`endif

   int     n_checks = 0;
   int     n_errors = 0;
   longint t = 0;

   // reference model
   int     m_state = 0;
   bit     m_irq   = 1'b0;
   int     m_fired = 0;
   int     m_ovr   = 0;
   longint m_next  = 0;
   longint m_p     = 1;
   int     m_cnt   = 0;

   bit     ack_auto = 1'b0;
   bit     prev_irq = 1'b0;
   longint rises[$];
   longint k;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic model_step();
      bit exp_now;
      bit fin;
      t++;
      if (ARESET) begin
         m_state = 0; m_irq = 0; m_fired = 0; m_ovr = 0;
      end else if (!cfg_enable) begin
         m_state = 0; m_irq = 0;
      end else begin
         exp_now = (t == m_next);
         case (m_state)
            0: if (cfg_start) begin
               m_p     = (cfg_period == 0) ? 1 : longint'(cfg_period);
               m_cnt   = int'(cfg_count);
               m_fired = 0;
               m_ovr   = 0;
               m_next  = t + longint'(cfg_delay) + 1;
               m_state = 1;
            end
            1, 2: if (exp_now) begin
               m_state = 3;
               m_irq   = 1;
               m_fired = sat(m_fired);
               m_next  = t + m_p;
            end
            default: begin
               fin = (m_cnt != 0) && (m_fired == m_cnt);
               if (irq_ack && fin) begin
                  m_state = 0; m_irq = 0;
               end else if (irq_ack && exp_now) begin
                  m_fired = sat(m_fired);
                  m_next  = t + m_p;
               end else if (irq_ack) begin
                  m_state = 2; m_irq = 0;
               end else if (exp_now) begin
`ifdef IRQ_SCHED_OVERRUN_CNT_EN
                  m_ovr = sat(m_ovr);
`endif
                  m_next = t + m_p;
               end
            end
         endcase
      end
   endtask

   task automatic tick();
      if (ack_auto) irq_ack = m_irq;
      @(posedge ACLK);
      model_step();
      #1;
      check("irq",     64'(irq),         64'(m_irq));
      check("busy",    64'(busy),        64'(m_state != 0));
      check("state",   64'(state_o),     64'(m_state));
      check("fired",   64'(fired_cnt),   64'(m_fired));
      check("overrun", 64'(overrun_cnt), 64'(m_ovr));
      if (irq === 1'b1 && !prev_irq) rises.push_back(t);
      prev_irq = (irq === 1'b1);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_start(input int d, input int p, input int c);
      cfg_delay  = 32'(d);
      cfg_period = 32'(p);
      cfg_count  = 16'(c);
      cfg_start  = 1'b1;
      rises.delete();
      tick();
      cfg_start  = 1'b0;
      k = t;
   endtask

   initial begin
      ARESET = 1'b1; cfg_enable = 1'b0; cfg_start = 1'b0; irq_ack = 1'b0;
      cfg_delay = '0; cfg_period = '0; cfg_count = '0;
      run(3);
      check("rst_fired", 64'(fired_cnt), 64'd0);
      ARESET = 1'b0; cfg_enable = 1'b1;
      run(2);

      // D=3 P=5 count=2, ack one cycle after each rise
      ack_auto = 1'b1;
      do_start(3, 5, 2);
      run(14);
      check("t1_nrises", 64'(rises.size()), 64'd2);
      if (rises.size() >= 2) begin
         check("t1_rise0", 64'(rises[0] - k), 64'd4);
         check("t1_rise1", 64'(rises[1] - k), 64'd9);
      end
      check("t1_fired", 64'(fired_cnt), 64'd2);
      check("t1_busy",  64'(busy),      64'd0);

      // D=0 P=0 unlimited, ack every cycle: continuous irq
      do_start(0, 0, 0);
      run(20);
      check("t2_nrises", 64'(rises.size()), 64'd1);
      check("t2_fired",  64'(fired_cnt),    64'd20);
      check("t2_irq",    64'(irq),          64'd1);
      check("t2_ovr",    64'(overrun_cnt),  64'd0);
      ack_auto = 1'b0; irq_ack = 1'b0;
      cfg_enable = 1'b0; tick(); cfg_enable = 1'b1;

      // P=4, no ack for 13 cycles after the first rise
      do_start(1, 4, 0);
      run(2);
      check("t3_rise", 64'(rises.size()), 64'd1);
      run(13);
      check("t3_ovr", 64'(overrun_cnt), 64'(OVR_EXP));
      check("t3_irq", 64'(irq),         64'd1);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      check("t3_irq_fall", 64'(irq), 64'd0);
      cfg_enable = 1'b0; tick(); cfg_enable = 1'b1;

      // start while busy ignored, then disable mid-RUN
      ack_auto = 1'b1;
      do_start(2, 10, 0);
      run(5);
      ack_auto = 1'b0; irq_ack = 1'b0;
      cfg_delay = 32'd0; cfg_period = 32'd1; cfg_count = 16'd1; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("t4_state_run", 64'(state_o),   64'(RUN));
      check("t4_fired",     64'(fired_cnt), 64'd1);
      cfg_enable = 1'b0; tick();
      check("t4_dis_irq",   64'(irq),       64'd0);
      check("t4_dis_state", 64'(state_o),   64'(IDLE));
      check("t4_dis_fired", 64'(fired_cnt), 64'd1);
      cfg_enable = 1'b1;

      // reset during WAIT_ACK, then restart with D=2
      do_start(0, 3, 0);
      run(3);
      check("t5_wait", 64'(state_o), 64'(WAIT_ACK));
      ARESET = 1'b1; tick(); ARESET = 1'b0;
      check("t5_rst_irq",   64'(irq),       64'd0);
      check("t5_rst_state", 64'(state_o),   64'(IDLE));
      check("t5_rst_fired", 64'(fired_cnt), 64'd0);
      do_start(2, 3, 0);
      run(4);
      check("t5_nrises", 64'(rises.size()), 64'd1);
      if (rises.size() >= 1) check("t5_rise0", 64'(rises[0] - k), 64'd3);

      // ack in IDLE and in DELAY is ignored
      cfg_enable = 1'b0; tick(); cfg_enable = 1'b1;
      irq_ack = 1'b1; run(2); irq_ack = 1'b0;
      check("t6_idle_state", 64'(state_o), 64'(IDLE));
      check("t6_idle_fired", 64'(fired_cnt), 64'd1);
      do_start(5, 2, 0);
      irq_ack = 1'b1; run(2); irq_ack = 1'b0;
      check("t6_delay_state", 64'(state_o),   64'(DELAY));
      check("t6_delay_fired", 64'(fired_cnt), 64'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         ARESET     = ($urandom_range(0, 299) == 0);
         cfg_enable = ($urandom_range(0, 39) != 0);
         cfg_start  = ($urandom_range(0, 7) == 0);
         cfg_delay  = 32'($urandom_range(0, 6));
         cfg_period = 32'($urandom_range(0, 6));
         cfg_count  = 16'($urandom_range(0, 4));
         ack_auto   = ($urandom_range(0, 1) == 0);
         irq_ack    = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
